// File: rtl/led_fade_pwm_pkg.sv
// Shared defaults and FSM state encoding for the LED fade PWM driver.
package led_fade_pwm_pkg;

  localparam int LED_CHANNELS = 8;
  localparam int LED_DUTY_W   = 8;

  typedef enum logic [1:0] {
    ST_ACCEPT  = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

endpackage

// File: rtl/led_fade_pwm_timebase.sv
// Prescaler and PWM step counter; flags the wrap to 0 and the
// registered period_start pulse in the cycle the counter reads 0.
module led_fade_pwm_timebase #(
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] pwm_cnt,
  output logic              wrap,
  output logic              period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              ps_q, ps_d;
  logic              step;

  always_comb begin
    step    = (presc_q == PLAST);
    wrap    = step && (cnt_q == MAX);
    presc_d = step ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
    end
    ps_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_cnt      = cnt_q;
  assign period_start = ps_q;

endmodule

// File: rtl/led_fade_pwm.sv
// 8-channel LED PWM driver: staged duty writes commit at a period
// boundary, then each channel's duty ramps toward its target.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int CHANNELS  = LED_CHANNELS,
  parameter int DUTY_W    = LED_DUTY_W,
  parameter int PRESCALE  = 16,
  parameter int FADE_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_chan,
  input  logic [DUTY_W-1:0]   cfg_duty,
  input  logic                cfg_commit,
  output logic [CHANNELS-1:0] led,
  output logic                period_start
);

  localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(FADE_STEP);

  logic [DUTY_W-1:0] pwm_cnt;
  logic              wrap;

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   hs;

  logic [DUTY_W-1:0] stg_q [CHANNELS];
  logic [DUTY_W-1:0] stg_d [CHANNELS];
  logic [DUTY_W-1:0] tgt_q [CHANNELS];
  logic [DUTY_W-1:0] tgt_d [CHANNELS];

  led_fade_pwm_timebase #(
    .DUTY_W   (DUTY_W),
    .PRESCALE (PRESCALE)
  ) u_tb (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

  always_comb begin
    hs      = cfg_valid && ready_q;
    state_d = state_q;
    unique case (state_q)
      ST_ACCEPT:  if (hs && cfg_commit) state_d = ST_PENDING;
      ST_PENDING: if (period_start) state_d = ST_APPLY;
      ST_APPLY:   state_d = ST_ACCEPT;
      default:    state_d = ST_ACCEPT;
    endcase
    // Registered so ready stays low through reset and the APPLY cycle.
    ready_d = (state_d == ST_ACCEPT);
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      stg_d[i] = stg_q[i];
      tgt_d[i] = tgt_q[i];
      if (hs && cfg_chan == 3'(i)) begin
        stg_d[i] = cfg_duty;
      end
      if (state_q == ST_APPLY) begin
        tgt_d[i] = stg_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCEPT;
      ready_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        stg_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      for (int i = 0; i < CHANNELS; i++) begin
        stg_q[i] <= stg_d[i];
        tgt_q[i] <= tgt_d[i];
      end
    end
  end

  assign cfg_ready = ready_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DUTY_W-1:0] cur_q, cur_d;
    logic [DUTY_W:0]   c_ext, t_ext, up, dn;
    logic              led_q, led_d;

    always_comb begin
      c_ext = {1'b0, cur_q};
      t_ext = {1'b0, tgt_q[g]};
      up    = c_ext + STEP_X;
      dn    = c_ext - STEP_X;
      cur_d = cur_q;
      if (wrap) begin
        if (FADE_STEP == 0) begin
          cur_d = tgt_q[g];
        end else if (c_ext < t_ext) begin
          cur_d = (up > t_ext) ? tgt_q[g] : up[DUTY_W-1:0];
        end else if (c_ext > t_ext) begin
          // Clamp at target; the borrow test keeps dn from wrapping.
          if (c_ext < STEP_X || dn < t_ext) begin
            cur_d = tgt_q[g];
          end else begin
            cur_d = dn[DUTY_W-1:0];
          end
        end
      end
      led_d = (pwm_cnt < cur_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cur_q <= '0;
        led_q <= 1'b0;
      end else begin
        cur_q <= cur_d;
        led_q <= led_d;
      end
    end

    assign led[g] = led_q;
  end

endmodule
